// File: rtl/mmio_bus_pkg.sv
// rtl/mmio_bus_pkg.sv - shared types and constants for the MMIO bus arbiter
//
// Purpose: the arbiter state encoding, the default timeout read word and the
//          watchdog counter width, shared by the arbiter top and its helpers.
// Contents:
//    arb_state_t        IDLE / BUSY / RESP
//    ERR_RDATA_DEFAULT  read word returned when a slave never answers
//    CNT_W              width of the watchdog counter
package mmio_bus_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } arb_state_t;

   localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

   // 8 bits covers the full legal TIMEOUT_CYCLES range of 2..255.
   localparam int CNT_W = 8;

endpackage

// File: rtl/mmio_bus_arbiter_rr_pick2.sv
// rtl/mmio_bus_arbiter_rr_pick2.sv - two-way round-robin winner selection
//
// Purpose: purely combinational pick between two requesters. On a tie the
//          requester that was not granted last time wins.
// Ports:
//    req0_i        requester 0 active
//    req1_i        requester 1 active
//    last_grant_i  index of the previously granted requester
//    winner_o      index of the winning requester (valid when any_req_o)
//    any_req_o     at least one requester active
module rr_pick2 (
   input  logic req0_i,
   input  logic req1_i,
   input  logic last_grant_i,
   output logic winner_o,
   output logic any_req_o
);

   always_comb begin
      any_req_o = req0_i | req1_i;
      if (req0_i && req1_i) begin
         winner_o = ~last_grant_i;
      end else begin
         winner_o = req1_i;
      end
   end

endmodule

// File: rtl/mmio_bus_arbiter.sv
// rtl/mmio_bus_arbiter.sv - two-master round-robin arbiter for one MMIO slave port
//
// Purpose: shares a single valid/ready MMIO slave between instruction fetch
//          (m0) and data load/store (m1). One transaction is outstanding at a
//          time; the slave request is registered and the response is steered
//          back to the granted master. A watchdog completes transactions to
//          silent slaves with ERR_RDATA and a timeout_err pulse.
// Ports:
//    clk, resetn                 clock, asynchronous active-low reset
//    m0_* / m1_*                 master requests (valid, addr, wdata, wstrb)
//                                and responses (rdata, one-cycle ready pulse)
//    s_valid/addr/wdata/wstrb    registered request to the slave
//    s_rdata, s_ready            slave response
//    grant                       current or last granted master index
//    timeout_err                 pulse alongside a watchdog-forced ready
module mmio_bus_arbiter
   import mmio_bus_pkg::*;
#(
   parameter int                ADDR_W         = 32,
   parameter int                DATA_W         = 32,
   parameter int                TIMEOUT_CYCLES = 16,
   parameter logic [DATA_W-1:0] ERR_RDATA      = DATA_W'(ERR_RDATA_DEFAULT)
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                m0_valid,
   input  logic [ADDR_W-1:0]   m0_addr,
   input  logic [DATA_W-1:0]   m0_wdata,
   input  logic [DATA_W/8-1:0] m0_wstrb,
   output logic [DATA_W-1:0]   m0_rdata,
   output logic                m0_ready,
   input  logic                m1_valid,
   input  logic [ADDR_W-1:0]   m1_addr,
   input  logic [DATA_W-1:0]   m1_wdata,
   input  logic [DATA_W/8-1:0] m1_wstrb,
   output logic [DATA_W-1:0]   m1_rdata,
   output logic                m1_ready,
   output logic                s_valid,
   output logic [ADDR_W-1:0]   s_addr,
   output logic [DATA_W-1:0]   s_wdata,
   output logic [DATA_W/8-1:0] s_wstrb,
   input  logic [DATA_W-1:0]   s_rdata,
   input  logic                s_ready,
   output logic                grant,
   output logic                timeout_err
);

   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   arb_state_t          state_q;
   logic [CNT_W-1:0]    cnt_q;
   logic                last_grant_q;
   logic                grant_q;
   logic                s_valid_q;
   logic [ADDR_W-1:0]   s_addr_q;
   logic [DATA_W-1:0]   s_wdata_q;
   logic [DATA_W/8-1:0] s_wstrb_q;
   logic [DATA_W-1:0]   m0_rdata_q;
   logic [DATA_W-1:0]   m1_rdata_q;
   logic                m0_ready_q;
   logic                m1_ready_q;
   logic                timeout_err_q;

   logic                winner_d;
   logic                any_req_d;

   rr_pick2 u_pick (
      .req0_i       (m0_valid),
      .req1_i       (m1_valid),
      .last_grant_i (last_grant_q),
      .winner_o     (winner_d),
      .any_req_o    (any_req_d)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         last_grant_q  <= 1'b1;   // m0 wins the first tie
         grant_q       <= 1'b0;
         s_valid_q     <= 1'b0;
         s_addr_q      <= '0;
         s_wdata_q     <= '0;
         s_wstrb_q     <= '0;
         m0_rdata_q    <= '0;
         m1_rdata_q    <= '0;
         m0_ready_q    <= 1'b0;
         m1_ready_q    <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         // Completion flags are single-cycle pulses.
         m0_ready_q    <= 1'b0;
         m1_ready_q    <= 1'b0;
         timeout_err_q <= 1'b0;

         case (state_q)
            IDLE: begin
               if (any_req_d) begin
                  grant_q      <= winner_d;
                  last_grant_q <= winner_d;
                  cnt_q        <= '0;
                  s_valid_q    <= 1'b1;
                  s_addr_q     <= winner_d ? m1_addr  : m0_addr;
                  s_wdata_q    <= winner_d ? m1_wdata : m0_wdata;
                  s_wstrb_q    <= winner_d ? m1_wstrb : m0_wstrb;
                  state_q      <= BUSY;
               end
            end

            BUSY: begin
               if (s_ready || (cnt_q == TO_LAST)) begin
                  if (grant_q) begin
                     m1_rdata_q <= s_ready ? s_rdata : ERR_RDATA;
                     m1_ready_q <= 1'b1;
                  end else begin
                     m0_rdata_q <= s_ready ? s_rdata : ERR_RDATA;
                     m0_ready_q <= 1'b1;
                  end
                  timeout_err_q <= ~s_ready;
                  s_valid_q     <= 1'b0;
                  state_q       <= RESP;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end

            RESP: begin
               // Ignore s_ready and m*_valid here: the slave may still echo
               // ready and the served master is still dropping valid. Read
               // data is cleared so an idle master always sees zero.
               m0_rdata_q <= '0;
               m1_rdata_q <= '0;
               state_q    <= IDLE;
            end

            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign s_valid     = s_valid_q;
   assign s_addr      = s_addr_q;
   assign s_wdata     = s_wdata_q;
   assign s_wstrb     = s_wstrb_q;
   assign m0_rdata    = m0_rdata_q;
   assign m1_rdata    = m1_rdata_q;
   assign m0_ready    = m0_ready_q;
   assign m1_ready    = m1_ready_q;
   assign grant       = grant_q;
   assign timeout_err = timeout_err_q;

endmodule
